// File: rtl/plab4_net_ingress_adapter_pkg.sv
// ---------------------------------------------------------------------------
// plab4_net_ingress_adapter_pkg
//
// Purpose : Shared definitions for the ingress adapter. These are the
//           network-message layout helpers: the total message width and the
//           offset of each field. A message is {dest, src, opaque, payload}
//           with dest at the MSBs. A domain enum for the 1-bit security
//           domain is also defined here.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package plab4_net_ingress_adapter_pkg;

  // Security domains. FIFO index == domain value.
  typedef enum logic {
    SD_0 = 1'b0,
    SD_1 = 1'b1
  } sec_dom_e;

  localparam int NUM_DOMAINS = 2;

  // Total network message width: payload + opaque + src + dest.
  function automatic int vc_net_msg_nbits(input int p, input int o, input int s);
    return p + o + 2 * s;
  endfunction

  // Field LSB offsets inside a message.
  function automatic int vc_net_msg_payload_lsb();
    return 0;
  endfunction

  function automatic int vc_net_msg_opaque_lsb(input int p);
    return p;
  endfunction

  function automatic int vc_net_msg_src_lsb(input int p, input int o);
    return p + o;
  endfunction

  function automatic int vc_net_msg_dest_lsb(input int p, input int o, input int s);
    return p + o + s;
  endfunction

endpackage

// File: rtl/plab4_net_ingress_fifo.sv
// ---------------------------------------------------------------------------
// plab4_net_ingress_fifo
//
// Purpose : Single-domain circular FIFO holding formatted network messages.
//           There is no bypass path. An entry written this cycle becomes
//           visible on o_head on the next cycle. A full FIFO does not accept
//           an enqueue even if a dequeue happens in the same cycle; that
//           decision is made upstream from o_full.
// Params  : p_nbits       - entry width
//           p_num_entries - depth (power of two, >= 2)
// Ports   : clk        in  clock
//           reset      in  synchronous active-high reset (pointers/count only)
//           i_enq      in  write request (ignored when full)
//           i_enq_msg  in  entry to write
//           i_deq      in  pop request (ignored when empty)
//           o_full     out occupancy == depth
//           o_empty    out occupancy == 0
//           o_head     out oldest entry (don't-care when empty)
// ---------------------------------------------------------------------------
module plab4_net_ingress_fifo
  import plab4_net_ingress_adapter_pkg::*;
#(
  parameter int p_nbits       = 39,
  parameter int p_num_entries = 2
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_enq,
  input  logic [p_nbits-1:0] i_enq_msg,
  input  logic               i_deq,
  output logic               o_full,
  output logic               o_empty,
  output logic [p_nbits-1:0] o_head
);

  localparam int PTR_W = $clog2(p_num_entries);
  localparam int CNT_W = PTR_W + 1;

  logic [p_nbits-1:0] r_mem [p_num_entries];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic w_enq;
  logic w_deq;

  assign o_full  = (r_count == CNT_W'(p_num_entries));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  // Local protection, so the FIFO never corrupts itself on a bad request.
  assign w_enq = i_enq && !o_full;
  assign w_deq = i_deq && !o_empty;

  // Storage is not reset. Stale contents are unreachable once the pointers
  // and count are cleared.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= i_enq_msg;
    end
  end

  // The depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/plab4_net_ingress_adapter.sv
// ---------------------------------------------------------------------------
// plab4_net_ingress_adapter
//
// Purpose : Per-terminal injection stage in front of one ring input port.
//           Client requests carry a 1-bit security domain. Each request is
//           stamped with {dest, src=p_port_id, per-domain opaque seq tag,
//           payload} and queued in that domain's FIFO. Only the FIFO of the
//           domain that currently owns the ring (cur_sd) is ever presented
//           or popped. The other domain's FIFO is never observed, which keeps
//           the two domains isolated from each other.
//
// Optional feature (macro PLAB4_NET_INGRESS_GUARD_EN):
//           When defined, the previous cur_sd is registered. in_val is held
//           low during the first cycle after any domain change, which lets
//           in-flight flits of the old domain drain.
//
// Ports   : clk         in  clock
//           reset       in  synchronous active-high reset
//           req_val     in  client request valid
//           req_rdy     out client request ready (= !full[req_sd])
//           req_dest    in  destination router id
//           req_payload in  payload
//           req_sd      in  security domain of request
//           in_val      out message valid to ring input port
//           in_rdy      in  ring input port ready
//           in_msg      out {dest, src, opaque, payload}; zero when !in_val
//           in_sd       out domain of presented message (= cur_sd)
//           cur_sd      in  domain currently owning the ring
// ---------------------------------------------------------------------------
module plab4_net_ingress_adapter
  import plab4_net_ingress_adapter_pkg::*;
#(
  parameter  int p_payload_nbits = 32,
  parameter  int p_opaque_nbits  = 3,
  parameter  int p_srcdest_nbits = 2,
  parameter  int p_port_id       = 0,
  parameter  int p_num_entries   = 2,
  localparam int m = vc_net_msg_nbits(p_payload_nbits, p_opaque_nbits, p_srcdest_nbits)
)(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_val,
  output logic                       req_rdy,
  input  logic [p_srcdest_nbits-1:0] req_dest,
  input  logic [p_payload_nbits-1:0] req_payload,
  input  logic                       req_sd,
  output logic                       in_val,
  input  logic                       in_rdy,
  output logic [m-1:0]               in_msg,
  output logic                       in_sd,
  input  logic                       cur_sd
);

  localparam logic [p_srcdest_nbits-1:0] SRC_ID = p_srcdest_nbits'(p_port_id);

  logic [NUM_DOMAINS-1:0]        w_full;
  logic [NUM_DOMAINS-1:0]        w_empty;
  logic [NUM_DOMAINS-1:0]        w_enq;
  logic [NUM_DOMAINS-1:0]        w_deq;
  logic [NUM_DOMAINS-1:0][m-1:0] w_head;
  logic                          w_guard;

  // -------------------------------------------------------------------------
  // Per-domain datapath: the opaque counter and the FIFO.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DOMAINS; gi++) begin : g_dom
      logic [p_opaque_nbits-1:0] r_opq_cnt;
      logic [m-1:0]              w_enq_msg;

      assign w_enq[gi] = req_val && req_rdy && (req_sd == 1'(gi));
      assign w_deq[gi] = in_val && in_rdy && (cur_sd == 1'(gi));

      assign w_enq_msg = {req_dest, SRC_ID, r_opq_cnt, req_payload};

      // The sequence tag advances only on accepted requests and wraps mod 2^o.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_opq_cnt <= '0;
        end else if (w_enq[gi]) begin
          r_opq_cnt <= r_opq_cnt + 1'b1;
        end
      end

      plab4_net_ingress_fifo #(
        .p_nbits       (m),
        .p_num_entries (p_num_entries)
      ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_enq     (w_enq[gi]),
        .i_enq_msg (w_enq_msg),
        .i_deq     (w_deq[gi]),
        .o_full    (w_full[gi]),
        .o_empty   (w_empty[gi]),
        .o_head    (w_head[gi])
      );
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Domain-switch guard
  // -------------------------------------------------------------------------
`ifdef PLAB4_NET_INGRESS_GUARD_EN
  logic r_prev_sd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_sd <= 1'b0;
    end else begin
      r_prev_sd <= cur_sd;
    end
  end

  assign w_guard = (cur_sd != r_prev_sd);
`else
  assign w_guard = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Client and ring handshakes
  // -------------------------------------------------------------------------
  // req_rdy depends only on registered occupancy. A pop in the same cycle
  // does not free a slot early, so there is no comb path from in_rdy.
  assign req_rdy = !w_full[req_sd];

  assign in_sd   = cur_sd;
  assign in_val  = !w_empty[cur_sd] && !w_guard;
  // Zeroing the message while it is invalid keeps the stale head of an idle
  // or guarded FIFO off the ring wires.
  assign in_msg  = in_val ? w_head[cur_sd] : '0;

endmodule

// File: tb/tb_plab4_net_ingress_adapter.sv
// ---------------------------------------------------------------------------
// tb_plab4_net_ingress_adapter
//
// Directed plus random bench for the ingress adapter (p_port_id = 1, depth 2).
// A per-domain scoreboard queue receives the expected formatted message
// whenever the bench model accepts a request. The queue entry is popped and
// compared when the model predicts an injection handshake. Every cycle,
// req_rdy, in_val, in_sd and in_msg are also checked against the model.
// ---------------------------------------------------------------------------
module tb_plab4_net_ingress_adapter;

  localparam int P     = 32;
  localparam int O     = 3;
  localparam int S     = 2;
  localparam int M     = P + O + 2 * S;
  localparam int DEPTH = 2;
  localparam int PORT  = 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_val;
  logic         req_rdy;
  logic [S-1:0] req_dest;
  logic [P-1:0] req_payload;
  logic         req_sd;
  logic         in_val;
  logic         in_rdy;
  logic [M-1:0] in_msg;
  logic         in_sd;
  logic         cur_sd;

  always #5 clk = ~clk;

  plab4_net_ingress_adapter #(
    .p_payload_nbits (P),
    .p_opaque_nbits  (O),
    .p_srcdest_nbits (S),
    .p_port_id       (PORT),
    .p_num_entries   (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_val     (req_val),
    .req_rdy     (req_rdy),
    .req_dest    (req_dest),
    .req_payload (req_payload),
    .req_sd      (req_sd),
    .in_val      (in_val),
    .in_rdy      (in_rdy),
    .in_msg      (in_msg),
    .in_sd       (in_sd),
    .cur_sd      (cur_sd)
  );

  int n_vec = 0;
  int n_err = 0;

  // Bench model state
  logic [M-1:0] sb0[$];
  logic [M-1:0] sb1[$];
  logic [O-1:0] m_opq0;
  logic [O-1:0] m_opq1;
  logic         m_prev;
  logic [S-1:0] src_id;

  // Last observed values (for explicit directed checks)
  logic [M-1:0] obs_msg;
  logic         obs_rdy;
  logic         obs_val;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive the inputs, check the outputs against the model,
  // then advance the model on the clock edge.
  task automatic step(input logic rst, input logic v, input logic sd,
                      input logic [S-1:0] d, input logic [P-1:0] pl,
                      input logic cur, input logic ir);
    int           qsz_req;
    int           qsz_cur;
    logic         e_rdy;
    logic         e_val;
    logic         e_guard;
    logic         enq;
    logic         deq;
    logic [M-1:0] e_head;
    logic [M-1:0] exp_pop;
    logic [M-1:0] cap_msg;

    reset = rst; req_val = v; req_sd = sd; req_dest = d;
    req_payload = pl; cur_sd = cur; in_rdy = ir;
    #1;
    qsz_req = sd  ? sb1.size() : sb0.size();
    qsz_cur = cur ? sb1.size() : sb0.size();
    e_rdy   = (qsz_req < DEPTH);
`ifdef PLAB4_NET_INGRESS_GUARD_EN
    e_guard = (cur != m_prev);
`else
    e_guard = 1'b0;
`endif
    e_val  = (qsz_cur != 0) && !e_guard;
    e_head = '0;
    if (qsz_cur != 0) e_head = cur ? sb1[0] : sb0[0];

    obs_msg = in_msg; obs_rdy = req_rdy; obs_val = in_val;
    cap_msg = in_msg;
    check("req_rdy", 64'(req_rdy), 64'(e_rdy));
    check("in_val",  64'(in_val),  64'(e_val));
    check("in_sd",   64'(in_sd),   64'(cur));
    if (!e_val) check("in_msg_idle", 64'(in_msg), 64'(0));

    enq = v && e_rdy;
    deq = e_val && ir;
    @(posedge clk);
    if (rst) begin
      sb0.delete(); sb1.delete();
      m_opq0 = '0; m_opq1 = '0;
      m_prev = 1'b0;
    end else begin
      if (deq) begin
        exp_pop = cur ? sb1.pop_front() : sb0.pop_front();
        check("inj_msg", 64'(cap_msg), 64'(exp_pop));
      end
      if (enq) begin
        if (sd) begin
          sb1.push_back({d, src_id, m_opq1, pl}); m_opq1 = m_opq1 + 1'b1;
        end else begin
          sb0.push_back({d, src_id, m_opq0, pl}); m_opq0 = m_opq0 + 1'b1;
        end
      end
      m_prev = cur;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [O-1:0] exp_opq;
    src_id = S'(PORT);
    m_opq0 = '0; m_opq1 = '0; m_prev = 1'b0;
    reset = 1'b1; req_val = 1'b0; req_sd = 1'b0; req_dest = '0;
    req_payload = '0; cur_sd = 1'b0; in_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Basic enqueue then inject: {2,1,0,0xA5}; the next sd-0 tag is 1
    step(0, 1, 0, 2'd2, 32'hA5, 0, 0);
    step(0, 0, 0, 2'd0, 32'h0,  0, 1);
    check("tp1_msg", 64'(obs_msg), 64'({2'd2, 2'd1, 3'd0, 32'hA5}));
    step(0, 1, 0, 2'd1, 32'h11, 0, 0);
    step(0, 0, 0, 2'd0, 32'h0,  0, 0);
    check("tp1_opq", 64'(obs_msg[P +: O]), 64'(3'd1));
    step(0, 0, 0, 2'd0, 32'h0,  0, 1);

    // Fill domain 1 while domain 0 owns the ring
    step(0, 1, 1, 2'd3, 32'h100, 0, 1);
    step(0, 1, 1, 2'd3, 32'h101, 0, 1);
    step(0, 1, 1, 2'd3, 32'h102, 0, 1);
    check("sd1_full_rdy", 64'(obs_rdy), 64'(0));
    step(0, 1, 0, 2'd0, 32'h200, 0, 1);
    check("sd0_open_rdy", 64'(obs_rdy), 64'(1));
    step(0, 0, 0, 2'd0, 32'h0,   0, 1);
    check("sd0_inject", 64'(obs_val), 64'(1));

    // Switch to domain 1 and drain in order
    step(0, 0, 0, 2'd0, 32'h0, 1, 1);
    step(0, 0, 0, 2'd0, 32'h0, 1, 1);
    step(0, 0, 0, 2'd0, 32'h0, 1, 1);
    step(0, 0, 0, 2'd0, 32'h0, 0, 1);

    // Nine back-to-back sd-0 requests after reset: tags 0..7,0
    step(1, 0, 0, 2'd0, 32'h0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, (i < 9), 0, 2'(i), 32'h300 + 32'(i), 0, 1);
      if (i >= 1) begin
        exp_opq = O'(i - 1);
        check("opq_wrap", 64'(obs_msg[P +: O]), 64'(exp_opq));
      end
    end

    // Full FIFO with a same-cycle dequeue: no bypass, enqueue lands next cycle
    step(0, 1, 0, 2'd1, 32'h400, 0, 0);
    step(0, 1, 0, 2'd1, 32'h401, 0, 0);
    step(0, 1, 0, 2'd1, 32'h402, 0, 1);
    check("full_deq_rdy", 64'(obs_rdy), 64'(0));
    step(0, 1, 0, 2'd1, 32'h402, 0, 0);
    check("after_deq_rdy", 64'(obs_rdy), 64'(1));
    repeat (3) step(0, 0, 0, 2'd0, 32'h0, 0, 1);

    // Head presented and not taken, domain leaves and returns
    step(0, 1, 0, 2'd2, 32'h500, 1, 0);
    step(0, 0, 0, 2'd0, 32'h0,   0, 0);
    step(0, 0, 0, 2'd0, 32'h0,   1, 1);
    step(0, 0, 0, 2'd0, 32'h0,   0, 1);
    step(0, 0, 0, 2'd0, 32'h0,   0, 1);

    // Reset with both FIFOs holding data
    step(0, 1, 0, 2'd1, 32'h600, 0, 0);
    step(0, 1, 1, 2'd1, 32'h601, 0, 0);
    step(1, 0, 0, 2'd0, 32'h0,   0, 0);
    step(0, 1, 0, 2'd1, 32'h700, 0, 0);
    check("rst_val", 64'(obs_val), 64'(0));
    check("rst_rdy", 64'(obs_rdy), 64'(1));
    step(0, 0, 0, 2'd0, 32'h0,   0, 1);
    check("rst_opq_msg", 64'(obs_msg), 64'({2'd1, 2'd1, 3'd0, 32'h700}));

    // Random traffic, including cross-domain enqueue/dequeue in the same cycle
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 32'($urandom),
           ($urandom_range(0, 3) == 0) ? ~cur_sd : cur_sd,
           1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
